// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: turns one request (device, register, R/W, length) into
// the complete CR/DR/SR register-access sequence on an i2c_top_module host bus,
// then reports a per-transfer status.
module i2c_xfer_sequencer #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TMO_CYC = 1048576,
  parameter int unsigned TMO_W   = 21
) (
  input  logic             i_sysclk,
  input  logic             i_reset,
  input  logic [7:0]       i_fdr,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_rw,
  input  logic [6:0]       i_req_dev,
  input  logic [7:0]       i_req_reg,
  input  logic [LEN_W-1:0] i_req_len,
  input  logic             i_wdata_valid,
  input  logic [7:0]       i_wdata,
  output logic             o_wdata_ready,
  output logic             o_rdata_valid,
  output logic [7:0]       o_rdata,
  output logic             o_rdata_last,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic             o_busy,
  output logic             o_wr_ena,
  output logic [4:0]       o_wr_addr,
  output logic [7:0]       o_wr_data,
  output logic             o_rd_ena,
  output logic [4:0]       o_rd_addr,
  input  logic [7:0]       i_rd_data,
  input  logic             i_interrupt
);

  localparam logic [4:0] A_FDR = 5'h04;
  localparam logic [4:0] A_CR  = 5'h08;
  localparam logic [4:0] A_SR  = 5'h0C;
  localparam logic [4:0] A_DR  = 5'h10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [4:0] {
    INIT_FDR, INIT_CR0, INIT_CR1, IDLE, START, TX_DEVW, TX_REG, TX_DATA,
    WDATA_WAIT, RESTART, TX_DEVR, RX_SETUP, RX_DUMMY, RX_CTRL, RX_RD,
    WAIT_IRQ, RD_SR, CLR_SR, STOP, DONE
  } state_t;

  state_t           state, state_n, ret, ret_n;
  logic [1:0]       ph, ph_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [6:0]       dev, dev_n;
  logic [7:0]       sub, sub_n;
  logic             rw, rw_n;
  logic             tx_chk, tx_n;
  logic             sr_mal, mal_n, sr_rxak, rxak_n;
  logic [7:0]       wbyte, wbyte_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic [1:0]       status_n;

  logic             wr_req, rd_req, acc_end;
  logic [4:0]       wr_a, rd_a;
  logic [7:0]       wr_v;

  logic             ready_n, wready_n, rvalid_n, rlast_n, done_n, busy_n;
  logic [7:0]       rdata_n, wr_data_n;
  logic             wr_en_n, rd_en_n;
  logic [4:0]       wr_addr_n, rd_addr_n;

  // Bus access each state needs: register target and value
  always_comb begin
    wr_req = 1'b0;
    wr_a   = A_CR;
    wr_v   = '0;
    rd_req = 1'b0;
    rd_a   = A_DR;
    unique case (state)
      INIT_FDR: begin wr_req = 1'b1; wr_a = A_FDR; wr_v = i_fdr; end
      INIT_CR0: begin wr_req = 1'b1; wr_v = 8'h80; end
      INIT_CR1: begin wr_req = 1'b1; wr_v = 8'hC0; end
      START:    begin wr_req = 1'b1; wr_v = 8'hF0; end
      TX_DEVW:  begin wr_req = 1'b1; wr_a = A_DR; wr_v = {dev, 1'b0}; end
      TX_REG:   begin wr_req = 1'b1; wr_a = A_DR; wr_v = sub; end
      TX_DATA:  begin wr_req = 1'b1; wr_a = A_DR; wr_v = wbyte; end
      RESTART:  begin wr_req = 1'b1; wr_v = 8'hF4; end
      TX_DEVR:  begin wr_req = 1'b1; wr_a = A_DR; wr_v = {dev, 1'b1}; end
      // A single-byte read must NACK its only byte, so TXAK goes in before the dummy read
      RX_SETUP: begin wr_req = 1'b1; wr_v = (cnt == '0) ? 8'hE8 : 8'hE0; end
      RX_DUMMY: rd_req = 1'b1;
      RX_CTRL: begin
        if (cnt == '0) begin
          wr_req = 1'b1; wr_v = 8'hC8;
        end else if (cnt == LEN_W'(1)) begin
          wr_req = 1'b1; wr_v = 8'hE8;
        end
      end
      RX_RD:    rd_req = 1'b1;
      RD_SR:    begin rd_req = 1'b1; rd_a = A_SR; end
      CLR_SR:   begin wr_req = 1'b1; wr_a = A_SR; wr_v = 8'h00; end
      STOP:     begin wr_req = 1'b1; wr_v = 8'hC0; end
      default:  ;
    endcase
  end

  // Next-state, strobe sequencing and registered-output next values
  always_comb begin
    state_n   = state;
    ret_n     = ret;
    ph_n      = ph;
    cnt_n     = cnt;
    dev_n     = dev;
    sub_n     = sub;
    rw_n      = rw;
    tx_n      = tx_chk;
    mal_n     = sr_mal;
    rxak_n    = sr_rxak;
    wbyte_n   = wbyte;
    tmo_n     = '0;
    status_n  = o_status;
    wr_en_n   = 1'b0;
    wr_addr_n = o_wr_addr;
    wr_data_n = o_wr_data;
    rd_en_n   = 1'b0;
    rd_addr_n = o_rd_addr;
    wready_n  = 1'b0;
    rvalid_n  = 1'b0;
    rdata_n   = o_rdata;
    rlast_n   = 1'b0;
    acc_end   = 1'b0;

    // Write: strobe cycle then one idle cycle. Read: strobe, idle, then sample.
    if (wr_req) begin
      if (ph == 2'd0) begin
        wr_en_n = 1'b1; wr_addr_n = wr_a; wr_data_n = wr_v; ph_n = 2'd1;
      end else begin
        ph_n = 2'd0; acc_end = 1'b1;
      end
    end else if (rd_req) begin
      if (ph == 2'd0) begin
        rd_en_n = 1'b1; rd_addr_n = rd_a; ph_n = 2'd1;
      end else if (ph == 2'd1) begin
        ph_n = 2'd2;
      end else begin
        ph_n = 2'd0; acc_end = 1'b1;
      end
    end

    unique case (state)
      INIT_FDR: if (acc_end) state_n = INIT_CR0;
      INIT_CR0: if (acc_end) state_n = INIT_CR1;
      INIT_CR1: if (acc_end) state_n = IDLE;
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          dev_n    = i_req_dev;
          sub_n    = i_req_reg;
          rw_n     = i_req_rw;
          cnt_n    = i_req_len;
          status_n = 2'b00;
          state_n  = START;
        end
      end
      START:   if (acc_end) state_n = TX_DEVW;
      TX_DEVW: if (acc_end) begin tx_n = 1'b1; ret_n = TX_REG; state_n = WAIT_IRQ; end
      TX_REG: begin
        if (acc_end) begin
          tx_n    = 1'b1;
          ret_n   = rw ? RESTART : WDATA_WAIT;
          state_n = WAIT_IRQ;
        end
      end
      WDATA_WAIT: begin
        if (i_wdata_valid) begin
          wready_n = 1'b1;
          wbyte_n  = i_wdata;
          state_n  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (acc_end) begin
          tx_n    = 1'b1;
          state_n = WAIT_IRQ;
          if (cnt == '0) begin
            ret_n = STOP;
          end else begin
            ret_n = WDATA_WAIT;
            cnt_n = cnt - LEN_W'(1);
          end
        end
      end
      RESTART:  if (acc_end) state_n = TX_DEVR;
      TX_DEVR:  if (acc_end) begin tx_n = 1'b1; ret_n = RX_SETUP; state_n = WAIT_IRQ; end
      RX_SETUP: if (acc_end) state_n = RX_DUMMY;
      RX_DUMMY: if (acc_end) begin tx_n = 1'b0; ret_n = RX_CTRL; state_n = WAIT_IRQ; end
      RX_CTRL: begin
        if (cnt > LEN_W'(1)) state_n = RX_RD;
        else if (acc_end)    state_n = RX_RD;
      end
      RX_RD: begin
        if (acc_end) begin
          rvalid_n = 1'b1;
          rdata_n  = i_rd_data;
          rlast_n  = (cnt == '0);
          if (cnt == '0) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt - LEN_W'(1);
            tx_n    = 1'b0;
            ret_n   = RX_CTRL;
            state_n = WAIT_IRQ;
          end
        end
      end
      WAIT_IRQ: begin
        if (i_interrupt) begin
          state_n = RD_SR;
        end else if (tmo == TMO_LAST) begin
          status_n = 2'b11;
          state_n  = STOP;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      RD_SR: begin
        if (acc_end) begin
          mal_n   = i_rd_data[4];
          rxak_n  = i_rd_data[0];
          state_n = CLR_SR;
        end
      end
      CLR_SR: begin
        if (acc_end) begin
          if (sr_mal) begin
            status_n = 2'b10; state_n = STOP;
          end else if (tx_chk && sr_rxak) begin
            status_n = 2'b01; state_n = STOP;
          end else begin
            state_n = ret;
          end
        end
      end
      STOP:    if (acc_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = INIT_FDR;
    endcase

    ready_n = (state_n == IDLE);
    busy_n  = !(state_n inside {INIT_FDR, INIT_CR0, INIT_CR1, IDLE});
    done_n  = (state_n == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      state         <= INIT_FDR;
      ret           <= INIT_FDR;
      ph            <= '0;
      cnt           <= '0;
      dev           <= '0;
      sub           <= '0;
      rw            <= 1'b0;
      tx_chk        <= 1'b0;
      sr_mal        <= 1'b0;
      sr_rxak       <= 1'b0;
      wbyte         <= '0;
      tmo           <= '0;
      o_status      <= '0;
      o_req_ready   <= 1'b0;
      o_wdata_ready <= 1'b0;
      o_rdata_valid <= 1'b0;
      o_rdata       <= '0;
      o_rdata_last  <= 1'b0;
      o_done        <= 1'b0;
      o_busy        <= 1'b0;
      o_wr_ena      <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_rd_ena      <= 1'b0;
      o_rd_addr     <= '0;
    end else begin
      state         <= state_n;
      ret           <= ret_n;
      ph            <= ph_n;
      cnt           <= cnt_n;
      dev           <= dev_n;
      sub           <= sub_n;
      rw            <= rw_n;
      tx_chk        <= tx_n;
      sr_mal        <= mal_n;
      sr_rxak       <= rxak_n;
      wbyte         <= wbyte_n;
      tmo           <= tmo_n;
      o_status      <= status_n;
      o_req_ready   <= ready_n;
      o_wdata_ready <= wready_n;
      o_rdata_valid <= rvalid_n;
      o_rdata       <= rdata_n;
      o_rdata_last  <= rlast_n;
      o_done        <= done_n;
      o_busy        <= busy_n;
      o_wr_ena      <= wr_en_n;
      o_wr_addr     <= wr_addr_n;
      o_wr_data     <= wr_data_n;
      o_rd_ena      <= rd_en_n;
      o_rd_addr     <= rd_addr_n;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer with a behavioural i2c_top_module
// register model (interrupt after each byte, SR flags, DR receive data).
module tb_i2c_xfer_sequencer;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_fdr;
  logic       i_req_valid, i_req_rw;
  logic [6:0] i_req_dev;
  logic [7:0] i_req_reg;
  logic [3:0] i_req_len;
  logic       i_wdata_valid;
  logic [7:0] i_wdata;
  logic       o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last, o_done, o_busy;
  logic [7:0] o_rdata, o_wr_data;
  logic [1:0] o_status;
  logic       o_wr_ena, o_rd_ena;
  logic [4:0] o_wr_addr, o_rd_addr;
  logic [7:0] tgt_rd;
  logic       irq;

  i2c_xfer_sequencer #(.LEN_W(4), .TMO_CYC(TMO), .TMO_W(21)) dut (
    .i_sysclk(clk), .i_reset(rst), .i_fdr(i_fdr),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rw(i_req_rw),
    .i_req_dev(i_req_dev), .i_req_reg(i_req_reg), .i_req_len(i_req_len),
    .i_wdata_valid(i_wdata_valid), .i_wdata(i_wdata), .o_wdata_ready(o_wdata_ready),
    .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata), .o_rdata_last(o_rdata_last),
    .o_done(o_done), .o_status(o_status), .o_busy(o_busy),
    .o_wr_ena(o_wr_ena), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_ena(o_rd_ena), .o_rd_addr(o_rd_addr), .i_rd_data(tgt_rd),
    .i_interrupt(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- target register model ----------------
  int          cyc = 0;
  int          nack_at = -1, mal_at = -1;
  logic        irq_off = 1'b0;
  logic [7:0]  rx_bytes [3];
  logic [15:0] wlog [$];
  int          wcyc [$];
  logic [8:0]  rq [$];
  int          viol = 0;
  logic        prev_strobe = 1'b0;
  logic        mal, rxak, rx_pend;
  logic [7:0]  cr, dr_val;
  int          pend, ndr, ri;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (o_rdata_valid) rq.push_back({o_rdata_last, o_rdata});
    if (o_wr_ena && o_rd_ena) viol <= viol + 1;
    if ((o_wr_ena || o_rd_ena) && prev_strobe) viol <= viol + 1;
    prev_strobe <= o_wr_ena || o_rd_ena;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0; mal <= 1'b0; rxak <= 1'b0; pend <= 0; rx_pend <= 1'b0;
      dr_val <= '0; tgt_rd <= '0; cr <= '0; ndr <= 0; ri <= 0;
    end else begin
      if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          irq <= 1'b1;
          if (rx_pend) begin dr_val <= rx_bytes[ri]; ri <= ri + 1; end
        end
      end
      if (o_wr_ena) begin
        wlog.push_back({3'b000, o_wr_addr, o_wr_data});
        wcyc.push_back(cyc);
        case (o_wr_addr)
          5'h08: cr <= o_wr_data;
          5'h0C: begin irq <= 1'b0; mal <= 1'b0; end
          5'h10: begin
            ndr  <= ndr + 1;
            rxak <= (ndr == nack_at);
            if (ndr == mal_at) begin mal <= 1'b1; irq <= 1'b1; end
            else if (!irq_off) begin pend <= 4; rx_pend <= 1'b0; end
          end
          default: ;
        endcase
      end
      if (o_rd_ena) begin
        case (o_rd_addr)
          5'h10: begin
            tgt_rd <= dr_val;
            if (cr[5] && !cr[4] && !irq_off) begin pend <= 4; rx_pend <= 1'b1; end
          end
          5'h0C: tgt_rd <= {1'b1, 1'b0, 1'b1, mal, 2'b00, irq, rxak};
          default: tgt_rd <= '0;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  logic [15:0] exp_log [$];
  logic [7:0]  wbuf [4];
  int          widx, wcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_len"}, 64'(wlog.size() - base), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      if (base + i < wlog.size())
        chk($sformatf("%s[%0d]", tag, i), 64'(wlog[base + i]), 64'(exp_log[i]));
  endtask

  task automatic feed();
    if (o_wdata_ready) begin
      widx++;
      if (widx < wcnt) i_wdata = wbuf[widx];
      else i_wdata_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_req_ready) begin seen = 1'b1; break; end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [3:0] len);
    @(negedge clk);
    i_req_rw = rw; i_req_dev = dev; i_req_reg = rg; i_req_len = len; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("accept_busy", 64'({o_busy, o_req_ready}), 64'(2'b10));
  endtask

  task automatic run_xfer(input int maxc, output logic [1:0] st);
    logic got;
    got = 1'b0;
    st  = 2'bxx;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      feed();
      if (o_done) begin got = 1'b1; st = o_status; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'({o_done, o_req_ready, o_busy}), 64'(3'b010));
  endtask

  task automatic load_wdata(input logic [7:0] b0, input logic [7:0] b1, input int n);
    wbuf[0] = b0; wbuf[1] = b1; wcnt = n; widx = 0;
    i_wdata = b0; i_wdata_valid = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] st;
    int b, rb, gap;
    logic seen;

    rst = 1'b1; i_fdr = 8'h2B; i_req_valid = 1'b0; i_req_rw = 1'b0;
    i_req_dev = '0; i_req_reg = '0; i_req_len = '0; i_wdata_valid = 1'b0; i_wdata = '0;
    wcnt = 0; widx = 0;
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last,
                              o_done, o_status, o_busy, o_wr_ena, o_wr_addr, o_wr_data,
                              o_rd_ena, o_rd_addr}), 64'd0);

    // init sequence
    b = wlog.size();
    rst = 1'b0;
    wait_ready("init_ready");
    exp_log = '{16'h042B, 16'h0880, 16'h08C0};
    chk_log("init_log", b);

    // write dev 0x50 reg 0x10, two bytes A5 5A
    load_wdata(8'hA5, 8'h5A, 2);
    b = wlog.size();
    send_req(1'b0, 7'h50, 8'h10, 4'd1);
    run_xfer(2000, st);
    chk("wr_status", 64'(st), 64'd0);
    chk("wr_consumed", 64'(widx), 64'd2);
    exp_log = '{16'h08F0, 16'h10A0, 16'h0C00, 16'h1010, 16'h0C00,
                16'h10A5, 16'h0C00, 16'h105A, 16'h0C00, 16'h08C0};
    chk_log("wr_log", b);

    // read dev 0x50 reg 0x00, three bytes
    b = wlog.size(); rb = rq.size();
    send_req(1'b1, 7'h50, 8'h00, 4'd2);
    run_xfer(2000, st);
    chk("rd_status", 64'(st), 64'd0);
    exp_log = '{16'h08F0, 16'h10A0, 16'h0C00, 16'h1000, 16'h0C00, 16'h08F4, 16'h10A1,
                16'h0C00, 16'h08E0, 16'h0C00, 16'h0C00, 16'h08E8, 16'h0C00, 16'h08C8};
    chk_log("rd_log", b);
    chk("rd_count", 64'(rq.size() - rb), 64'd3);
    if (rq.size() >= rb + 3) begin
      chk("rd_byte0", 64'(rq[rb]),     64'(9'h011));
      chk("rd_byte1", 64'(rq[rb + 1]), 64'(9'h022));
      chk("rd_byte2", 64'(rq[rb + 2]), 64'(9'h133));
    end

    // address NACK on a read request
    b = wlog.size(); rb = rq.size();
    nack_at = ndr;
    send_req(1'b1, 7'h50, 8'h20, 4'd0);
    run_xfer(2000, st);
    nack_at = -1;
    chk("nack_status", 64'(st), 64'd1);
    exp_log = '{16'h08F0, 16'h10A0, 16'h0C00, 16'h08C0};
    chk_log("nack_log", b);
    chk("nack_no_rdata", 64'(rq.size() - rb), 64'd0);

    // interrupt never arrives -> timeout
    irq_off = 1'b1;
    b = wlog.size();
    send_req(1'b0, 7'h50, 8'h10, 4'd0);
    run_xfer(TMO + 200, st);
    irq_off = 1'b0;
    chk("tmo_status", 64'(st), 64'd3);
    exp_log = '{16'h08F0, 16'h10A0, 16'h08C0};
    chk_log("tmo_log", b);
    gap = (wlog.size() >= b + 3) ? (wcyc[b + 2] - wcyc[b + 1]) : -1;
    chk("tmo_gap_window", 64'((gap >= TMO) && (gap <= TMO + 4)), 64'd1);

    // arbitration lost on the register byte
    b = wlog.size();
    mal_at = ndr + 1;
    send_req(1'b0, 7'h50, 8'h10, 4'd0);
    run_xfer(2000, st);
    mal_at = -1;
    chk("mal_status", 64'(st), 64'd2);
    exp_log = '{16'h08F0, 16'h10A0, 16'h0C00, 16'h1010, 16'h0C00, 16'h08C0};
    chk_log("mal_log", b);

    // reset while the first data byte is on the bus
    load_wdata(8'hA5, 8'h5A, 2);
    send_req(1'b0, 7'h50, 8'h10, 4'd1);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      feed();
      if (o_wr_ena && o_wr_addr == 5'h10 && o_wr_data == 8'hA5) begin seen = 1'b1; break; end
    end
    chk("txdata_reached", 64'(seen), 64'd1);
    rst = 1'b1;
    i_wdata_valid = 1'b0;
    #1;
    chk("midreset_outputs", 64'({o_wr_ena, o_rd_ena, o_busy, o_wdata_ready, o_done, o_req_ready}),
        64'd0);
    i_fdr = 8'h3C;
    repeat (3) @(negedge clk);
    b = wlog.size();
    rst = 1'b0;
    wait_ready("reinit_ready");
    exp_log = '{16'h043C, 16'h0880, 16'h08C0};
    chk_log("reinit_log", b);

    load_wdata(8'h77, 8'h00, 1);
    b = wlog.size();
    send_req(1'b0, 7'h50, 8'h10, 4'd0);
    run_xfer(2000, st);
    chk("post_reset_status", 64'(st), 64'd0);
    exp_log = '{16'h08F0, 16'h10A0, 16'h0C00, 16'h1010, 16'h0C00, 16'h1077, 16'h0C00, 16'h08C0};
    chk_log("post_reset_log", b);

    chk("bus_strobe_rules", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
